// File: rtl/gf10_pkg.sv
// GF(2^10) field definitions shared by the BCH syndrome datapath.
// Field generated by p(x) = x^10 + x^3 + 1, so alpha^10 = alpha^3 + 1.
package gf10_pkg;

  localparam int GF_M = 10;
  localparam logic [GF_M:0] GF_POLY = 11'h409;

  typedef logic [GF_M-1:0] gf10_t;

  // Multiply a field element by alpha (i.e. by x), folding x^10 back as x^3 + 1.
  function automatic gf10_t gf10_mul_x(input gf10_t a);
    gf10_t r;
    r = {a[GF_M-2:0], 1'b0};
    if (a[GF_M-1]) begin
      r = r ^ GF_POLY[GF_M-1:0];
    end
    return r;
  endfunction

  // alpha^k as a polynomial-basis vector; intended for elaboration-time constants.
  function automatic gf10_t gf10_alpha_pow(input int k);
    gf10_t v;
    v = gf10_t'(1);
    for (int i = 0; i < k; i++) begin
      v = gf10_mul_x(v);
    end
    return v;
  endfunction

endpackage

// File: rtl/gf10_alpha_pow_mult.sv
// Constant multiplier: o_p = i_a * alpha^K in GF(2^10).
// Column i of the XOR matrix is alpha^(K+i), so each output bit is the XOR of
// the input bits whose column has a 1 in that position.
module gf10_alpha_pow_mult
  import gf10_pkg::*;
#(
  parameter int K = 1
) (
  input  gf10_t i_a,
  output gf10_t o_p
);

  gf10_t w_term [GF_M];

  for (genvar i = 0; i < GF_M; i++) begin : g_col
    localparam gf10_t COL = gf10_alpha_pow(K + i);
    assign w_term[i] = i_a[i] ? COL : '0;
  end

  // XOR the selected columns together.
  always_comb begin
    o_p = '0;
    for (int i = 0; i < GF_M; i++) begin
      o_p = o_p ^ w_term[i];
    end
  end

endmodule

// File: rtl/bch_syndrome_gf10.sv
// Serial BCH syndrome generator over GF(2^10).
// Bits arrive highest degree first; each S_j is updated by Horner's rule
// S_j <= S_j * alpha^j + r_i. After N bits the set is held until taken.
module bch_syndrome_gf10
  import gf10_pkg::*;
#(
  parameter int N = 1023,
  parameter int T = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_bit,
  output logic                in_ready,
  output logic                synd_valid,
  output logic [GF_M*2*T-1:0] synd,
  output logic                err_detect,
  input  logic                out_ready
);

  localparam int NS = 2 * T;
  localparam logic [9:0] CNT_LAST = 10'(N - 1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t     r_state;
  logic [9:0] r_cnt;
  logic       r_in_ready;
  logic       r_synd_valid;
  logic       r_err;
  gf10_t      r_synd [NS];

  gf10_t      w_mult [NS];
  gf10_t      w_next [NS];
  logic       w_acc;
  logic       w_last;
  logic       w_any;

  assign w_acc  = in_valid & r_in_ready;
  assign w_last = w_acc & (r_cnt == CNT_LAST);

  for (genvar j = 0; j < NS; j++) begin : g_synd
    gf10_alpha_pow_mult #(.K(j + 1)) u_mul (
      .i_a (r_synd[j]),
      .o_p (w_mult[j])
    );
    assign synd[GF_M*j +: GF_M] = r_synd[j];
  end

  // Next Horner value per syndrome; the first bit of a frame overwrites the old set.
  always_comb begin
    w_any = 1'b0;
    for (int j = 0; j < NS; j++) begin
      if (r_cnt == '0) begin
        w_next[j] = {{(GF_M-1){1'b0}}, in_bit};
      end else begin
        w_next[j] = w_mult[j] ^ {{(GF_M-1){1'b0}}, in_bit};
      end
      w_any = w_any | (|w_next[j]);
    end
  end

  // Frame sequencing: count accepted bits, hold the result until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_cnt        <= '0;
      r_in_ready   <= 1'b1;
      r_synd_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_last) begin
            r_cnt        <= '0;
            r_state      <= ST_HOLD;
            r_in_ready   <= 1'b0;
            r_synd_valid <= 1'b1;
            r_err        <= w_any;
          end else if (w_acc) begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        ST_HOLD: begin
          if (r_synd_valid && out_ready) begin
            r_state      <= ST_RUN;
            r_in_ready   <= 1'b1;
            r_synd_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

  // Syndrome registers advance only on an accepted bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NS; j++) begin
        r_synd[j] <= '0;
      end
    end else if (w_acc) begin
      for (int j = 0; j < NS; j++) begin
        r_synd[j] <= w_next[j];
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign synd_valid = r_synd_valid;
  assign err_detect = r_err;

endmodule

// File: tb/tb_bch_syndrome_gf10.sv
// Self-checking bench for bch_syndrome_gf10 (N=1023, T=8).
// Expected syndromes come from a software Horner model pushed per frame.
module tb_bch_syndrome_gf10;

  localparam int N  = 1023;
  localparam int T  = 8;
  localparam int NS = 2 * T;
  localparam int W  = 10 * NS;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_bit;
  logic         in_ready;
  logic         synd_valid;
  logic [W-1:0] synd;
  logic         err_detect;
  logic         out_ready;

  typedef struct packed {
    logic [W-1:0] s;
    logic         err;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   errors;

  bch_syndrome_gf10 #(.N(N), .T(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .synd_valid (synd_valid),
    .synd       (synd),
    .err_detect (err_detect),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
    logic [18:0] p;
    p = '0;
    for (int i = 0; i < 10; i++) if (b[i]) p = p ^ (19'(a) << i);
    for (int i = 18; i >= 10; i--) if (p[i]) p = p ^ (19'h409 << (i - 10));
    return p[9:0];
  endfunction

  function automatic exp_t model(input logic [N-1:0] f);
    logic [9:0] aj [NS];
    logic [9:0] s  [NS];
    logic [9:0] a;
    exp_t e;
    a = 10'h001;
    for (int j = 0; j < NS; j++) begin
      a = gf_mul(a, 10'h002);
      aj[j] = a;
      s[j] = '0;
    end
    for (int d = N - 1; d >= 0; d--)
      for (int j = 0; j < NS; j++)
        s[j] = gf_mul(s[j], aj[j]) ^ {9'b0, f[d]};
    for (int j = 0; j < NS; j++) e.s[10*j +: 10] = s[j];
    e.err = |e.s;
    return e;
  endfunction

  function automatic logic [N-1:0] rand_frame();
    logic [N-1:0] f;
    for (int i = 0; i < N; i++) f[i] = 1'($urandom_range(1));
    return f;
  endfunction

  // Drive the top nbits (highest degree first); push the model result for full frames.
  task automatic drive_frame(input logic [N-1:0] f, input int nbits, input int gap_pct,
                             input bit keep_valid);
    int b;
    for (int d = N - 1; d >= N - nbits; d--) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_bit   = f[d];
      b = 0;
      while (!in_ready && b < 50) begin
        @(posedge clk); #1;
        b++;
      end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL ready_timeout: in_ready=%b required 1 at degree %0d", in_ready, d);
        in_valid = 1'b0;
        return;
      end
      if (d == 0) begin
        checks++;
        if (synd_valid !== 1'b0) begin
          errors++;
          $display("FAIL latency_pre: synd_valid=%b required 0 before last accept", synd_valid);
        end
      end
      @(posedge clk); #1;
    end
    in_valid = keep_valid;
    if (nbits == N) q.push_back(model(f));
  endtask

  task automatic check_synd(input string name);
    exp_t e;
    checks++;
    if (synd_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: synd_valid=%b required 1 one cycle after last accept", name, synd_valid);
    end
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_queue: scoreboard empty, required one entry", name);
      return;
    end
    e = q.pop_front();
    checks++;
    if (synd !== e.s) begin
      errors++;
      $display("FAIL %s_synd: got %h required %h", name, synd, e.s);
    end
    checks++;
    if (err_detect !== e.err) begin
      errors++;
      $display("FAIL %s_err: got %b required %b", name, err_detect, e.err);
    end
  endtask

  task automatic release_synd(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || synd_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: in_ready=%b synd_valid=%b required 1/0", name, in_ready, synd_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++;
    if (synd_valid !== 1'b0) begin errors++; $display("FAIL reset_synd_valid: got %b required 0", synd_valid); end
    checks++;
    if (err_detect !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err_detect); end
    checks++;
    if (synd !== '0) begin errors++; $display("FAIL reset_synd: got %h required 0", synd); end
  endtask

  task automatic test_all_zero();
    drive_frame('0, N, 0, 1'b0);
    check_synd("all_zero");
    checks++;
    if (synd !== '0 || err_detect !== 1'b0) begin
      errors++;
      $display("FAIL all_zero_const: synd=%h err=%b required 0/0", synd, err_detect);
    end
    release_synd("all_zero");
  endtask

  task automatic test_degree0();
    logic [N-1:0] f;
    logic ok;
    f = '0; f[0] = 1'b1;
    drive_frame(f, N, 0, 1'b0);
    check_synd("deg0");
    ok = 1'b1;
    for (int j = 0; j < NS; j++) if (synd[10*j +: 10] !== 10'h001) ok = 1'b0;
    checks++;
    if (!ok || err_detect !== 1'b1) begin
      errors++;
      $display("FAIL deg0_const: synd=%h err=%b required all S_j=001 err=1", synd, err_detect);
    end
    release_synd("deg0");
  endtask

  task automatic test_degree1();
    logic [N-1:0] f;
    f = '0; f[1] = 1'b1;
    drive_frame(f, N, 0, 1'b0);
    check_synd("deg1");
    checks++;
    if (synd[9:0] !== 10'h002) begin errors++; $display("FAIL deg1_s1: got %h required 002", synd[9:0]); end
    checks++;
    if (synd[29:20] !== 10'h008) begin errors++; $display("FAIL deg1_s3: got %h required 008", synd[29:20]); end
    checks++;
    if (synd[99:90] !== 10'h009) begin errors++; $display("FAIL deg1_s10: got %h required 009", synd[99:90]); end
    release_synd("deg1");
  endtask

  task automatic test_degree1022();
    logic [N-1:0] f;
    f = '0; f[N-1] = 1'b1;
    drive_frame(f, N, 0, 1'b0);
    check_synd("deg1022");
    checks++;
    if (synd[9:0] !== 10'h204) begin errors++; $display("FAIL deg1022_s1: got %h required 204", synd[9:0]); end
    checks++;
    if (synd[19:10] !== 10'h102) begin errors++; $display("FAIL deg1022_s2: got %h required 102", synd[19:10]); end
    release_synd("deg1022");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] snap;
    int bad;
    drive_frame(rand_frame(), N, 0, 1'b1);
    check_synd("bp_first");
    snap = synd;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || synd_valid !== 1'b1 || synd !== snap) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d cycles unstable, required 0 (in_ready=%b synd=%h)", bad, in_ready, synd);
    end
    release_synd("bp");
    drive_frame(rand_frame(), N, 0, 1'b0);
    check_synd("bp_next");
    release_synd("bp_next");
  endtask

  task automatic test_reset_midframe();
    drive_frame(rand_frame(), 500, 30, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (synd !== '0 || synd_valid !== 1'b0 || err_detect !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: synd=%h valid=%b err=%b ready=%b required 0/0/0/1",
               synd, synd_valid, err_detect, in_ready);
    end
    #3 rst = 1'b0;
    @(posedge clk); #1;
    drive_frame(rand_frame(), N, 30, 1'b0);
    check_synd("after_reset");
    release_synd("after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_all_zero();
    test_degree0();
    test_degree1();
    test_degree1022();
    test_backpressure();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bch_syndrome_gf10.md
Name: bch_syndrome_gf10

Overview:
Serial syndrome generator for the BCH decoder over GF(2^10), with primitive polynomial p(x)=x^10+x^3+1 (alpha^10 = alpha^3 + 1).
- Accepts a received codeword one bit per cycle, highest-degree coefficient r[N-1] first.
- Computes S_j = r(alpha^j) for j=1..2T by parallel Horner recursion.
- Presents the syndrome set to the downstream key-equation solver, which consumes it through GF(2^10) multipliers, using a valid/ready handshake.

Parameters:
N, 1023, codeword length in bits (2..1023).
T, 8, error-correction capability; 2T syndromes are produced (1..16).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  in_bit is valid this cycle
in_bit  in  1  received codeword bit
in_ready  out  1  block accepts a bit this cycle
synd_valid  out  1  syndrome set is complete and held
synd  out  10*2T  packed syndromes; S_j occupies bits [10*j-1 : 10*(j-1)], j=1..2T
err_detect  out  1  OR of all syndrome bits; qualified by synd_valid
out_ready  in  1  downstream accepts the syndrome set

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high, and forces:
  - state RUN, bit counter cnt=0
  - all S_j=0, synd_valid=0, err_detect=0
  - in_ready=1 once rst deasserts
- States:
  - RUN: in_ready=1, synd_valid=0.
  - HOLD: in_ready=0, synd_valid=1.
- Accept: a bit is accepted when in_valid & in_ready. Nothing changes in a cycle with no accept.
- Horner update, per j, on accept:
  - cnt==0: S_j <= {9'b0, in_bit}. The previous frame's contents are discarded, with no separate clear cycle.
  - cnt>0: S_j <= (S_j * alpha^j) XOR {9'b0, in_bit}.
  - The multiply is by a constant, reduced modulo p(x), and fully combinational within the cycle.
- Counter: cnt is 10 bits and increments on each accept.
  - On accepting the bit with cnt==N-1: cnt <= 0 and state <= HOLD.
  - The final S_j and synd_valid=1 appear in the next cycle, so latency from the last accepted bit to synd_valid is 1 cycle.
- HOLD:
  - synd and err_detect stay stable; in_valid is ignored (in_ready=0).
  - When synd_valid & out_ready, state <= RUN.
  - in_ready rises the cycle after the handshake, giving one bubble cycle per frame.
  - synd contents remain readable until overwritten by the next frame's first accepted bit.
- err_detect: registered; updated together with the final S_j and equal to |synd.
- in_valid gaps mid-frame: state and cnt are frozen.
- Reset mid-frame or mid-HOLD: the partial frame is dropped. The next accepted bit is treated as r[N-1] of a new frame.
- out_ready high in RUN: no effect.
- Arithmetic:
  - GF(2^10) addition is bitwise XOR.
  - The alpha^j constant multipliers use the fixed reduction x^10 -> x^3 + 1.
  - Exponents j range 1..2T ≤ 32; no wider field arithmetic is needed.

Decomposition:
- Shared package `gf10_pkg` holds:
  - GF_M=10
  - primitive polynomial constant 11'h409
  - a function returning alpha^k as a 10-bit vector for elaboration-time constant generation
  - the gf10 element type
- Natural sub-module: `gf10_alpha_pow_mult`.
  - Parameter K; out = in * alpha^K; purely combinational XOR network derived from the package function.
  - Instantiated 2T times via generate.
- Top level holds the FSM, cnt, syndrome registers and handshake.

Test Plan:
1. All-zero codeword, N=1023, T=8, in_valid held high → synd_valid rises 1 cycle after the 1023rd accept; all S_j=10'h000; err_detect=0.
2. Single 1 at degree 0 (last bit) → every S_j=10'h001; err_detect=1.
3. Single 1 at degree 1 (second-to-last bit) → S_1=10'h002, S_3=10'h008, S_10=10'h009 (alpha^10 = x^3+1).
4. Single 1 at degree 1022 (first bit) → S_1=alpha^-1=10'h204; S_2=S_1^2=alpha^-2=10'h102.
5. Backpressure: out_ready held low 20 cycles after a frame, in_valid high → in_ready=0 and synd stable throughout; after the out_ready pulse, in_ready=1 next cycle and the next frame's syndromes are correct.
6. Random in_valid gaps plus rst pulsed at bit 500 → outputs reset immediately (async); the following full frame yields syndromes matching a software model.
